// File: rtl/rx_frame_dispatcher.sv
// rtl/rx_frame_dispatcher.sv - store-and-forward receive frame router to NUM_CH channels
module rx_frame_dispatcher #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   validin,
  input  logic                   sof,
  input  logic                   eof,
  input  logic [31:0]            datain,
  input  logic [47:0]            inthwaddr,
  input  logic [16*NUM_CH-1:0]   chkey,
  input  logic [NUM_CH-1:0]      chmode,
  input  logic [NUM_CH-1:0]      chen,
  output logic [NUM_CH-1:0]      outvalid,
  input  logic [NUM_CH-1:0]      outready,
  output logic                   outsof,
  output logic                   outeof,
  output logic [31:0]            dataout,
  output logic                   busy,
  output logic [15:0]            framecount,
  output logic [15:0]            dropcount
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RECV     = 3'd1;
  localparam logic [2:0] S_CLASSIFY = 3'd2;
  localparam logic [2:0] S_DRAIN    = 3'd3;
  localparam logic [2:0] S_DROPWAIT = 3'd4;

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C     = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   W3_C      = (ADDR_W+1)'(3);
  localparam logic [ADDR_W:0]   W5_C      = (ADDR_W+1)'(5);
  localparam logic [ADDR_W:0]   W9_C      = (ADDR_W+1)'(9);
  localparam logic [ADDR_W:0]   MIN_ETH   = (ADDR_W+1)'(4);
  localparam logic [ADDR_W:0]   MIN_UDP   = (ADDR_W+1)'(10);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR0     = '0;

  logic [31:0]       mem [0:DEPTH-1];
  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ADDR_W:0]   cnt;
  logic              ovf;
  logic [47:0]       dstmac;
  logic [15:0]       ethertype;
  logic [3:0]        ihl;
  logic [7:0]        proto;
  logic [15:0]       udpport;
  logic [ADDR_W-1:0] rdaddr;
  logic [ADDR_W-1:0] lastaddr;
  logic              ext;
  logic              ext_nxt;
  logic [NUM_CH-1:0] match;
  logic [NUM_CH-1:0] sel_oh;
  logic              found;
  logic              dst_ok;
  logic              base_ok;
  logic              udp_ok;
  logic              xfer;
  logic              drop_evt;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  always_comb begin
    dst_ok  = (dstmac == inthwaddr) || (dstmac == {48{1'b1}});
    base_ok = dst_ok && !ovf && (cnt >= MIN_ETH);
    udp_ok  = (ethertype == 16'h0800) && (ihl == 4'd5) && (proto == 8'd17) && (cnt >= MIN_UDP);
    match   = '0;
    sel_oh  = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      match[i] = chen[i] && base_ok &&
                 (chmode[i] ? (udp_ok && (udpport == chkey[16*i +: 16]))
                            : (ethertype == chkey[16*i +: 16]));
      if (match[i] && !found) begin
        sel_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  // Tracks a foreign frame that began while the buffer was owned by the drain side.
  always_comb begin
    ext_nxt = ext;
    if (validin && sof)
      ext_nxt = !eof;
    else if (validin && eof)
      ext_nxt = 1'b0;
  end

  assign xfer = (state == S_DRAIN) && (|(outvalid & outready));

  always_comb begin
    drop_evt = 1'b0;
    case (state)
      S_IDLE:     drop_evt = validin && sof && eof;
      S_RECV:     drop_evt = validin && sof;
      S_CLASSIFY: drop_evt = (validin && sof) || !found;
      S_DRAIN:    drop_evt = validin && sof;
      S_DROPWAIT: drop_evt = validin && sof;
      default:    drop_evt = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (validin && sof && !eof) state_nxt = S_RECV;
      S_RECV:
        if (validin && sof && eof)       state_nxt = S_IDLE;
        else if (validin && !sof && eof) state_nxt = S_CLASSIFY;
      S_CLASSIFY:
        if (found)        state_nxt = S_DRAIN;
        else if (ext_nxt) state_nxt = S_DROPWAIT;
        else              state_nxt = S_IDLE;
      S_DRAIN:
        if (xfer && outeof) state_nxt = ext_nxt ? S_DROPWAIT : S_IDLE;
      S_DROPWAIT:
        if (validin && eof) state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  assign wr_en   = validin && (((state == S_IDLE) && sof) ||
                               ((state == S_RECV) && (sof || (cnt < DEPTH_CNT))));
  assign wr_addr = sof ? ADDR0 : cnt[ADDR_W-1:0];

  always_ff @(posedge clock) begin
    if (wr_en)
      mem[wr_addr] <= datain;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      cnt        <= '0;
      ovf        <= 1'b0;
      dstmac     <= '0;
      ethertype  <= '0;
      ihl        <= '0;
      proto      <= '0;
      udpport    <= '0;
      rdaddr     <= '0;
      lastaddr   <= '0;
      ext        <= 1'b0;
      outvalid   <= '0;
      outsof     <= 1'b0;
      outeof     <= 1'b0;
      dataout    <= '0;
      framecount <= '0;
      dropcount  <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      ext   <= ((state == S_CLASSIFY) || (state == S_DRAIN)) ? ext_nxt : 1'b0;

      if (drop_evt && (dropcount != 16'hFFFF))
        dropcount <= dropcount + 16'd1;

      // Header fields are picked off by word index while the frame streams in.
      if (validin && ((state == S_IDLE) || (state == S_RECV))) begin
        if (sof) begin
          dstmac[47:16] <= datain;
          cnt           <= ONE_C;
          ovf           <= 1'b0;
        end else if (state == S_RECV) begin
          if (cnt == DEPTH_CNT) begin
            ovf <= 1'b1;
          end else begin
            cnt <= cnt + ONE_C;
            if (cnt == ONE_C)
              dstmac[15:0] <= datain[31:16];
            if (cnt == W3_C) begin
              ethertype <= datain[31:16];
              ihl       <= datain[11:8];
            end
            if (cnt == W5_C)
              proto <= datain[7:0];
            if (cnt == W9_C)
              udpport <= datain[15:0];
          end
        end
      end

      case (state)
        S_CLASSIFY: begin
          if (found) begin
            outvalid <= sel_oh;
            outsof   <= 1'b1;
            outeof   <= (cnt == ONE_C);
            dataout  <= mem[ADDR0];
            rdaddr   <= ADDR0;
            lastaddr <= cnt[ADDR_W-1:0] - ONE_A;
          end
        end
        S_DRAIN: begin
          if (xfer) begin
            if (outeof) begin
              outvalid   <= '0;
              outsof     <= 1'b0;
              outeof     <= 1'b0;
              framecount <= framecount + 16'd1;
            end else begin
              rdaddr  <= rdaddr + ONE_A;
              dataout <= mem[rdaddr + ONE_A];
              outsof  <= 1'b0;
              outeof  <= ((rdaddr + ONE_A) == lastaddr);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_dispatcher.sv
// tb/tb_rx_frame_dispatcher.sv - directed self-checking bench for rx_frame_dispatcher
module tb_rx_frame_dispatcher;

  localparam int NUM_CH = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 validin = 1'b0;
  logic                 sof = 1'b0;
  logic                 eof = 1'b0;
  logic [31:0]          datain = '0;
  logic [47:0]          inthwaddr = 48'h0200_1122_3344;
  logic [16*NUM_CH-1:0] chkey = {16'h0000, 16'h0000, 16'd68, 16'h0806};
  logic [NUM_CH-1:0]    chmode = 4'b0010;
  logic [NUM_CH-1:0]    chen = 4'b0011;
  logic [NUM_CH-1:0]    outvalid;
  logic [NUM_CH-1:0]    outready = 4'hF;
  logic                 outsof;
  logic                 outeof;
  logic [31:0]          dataout;
  logic                 busy;
  logic [15:0]          framecount;
  logic [15:0]          dropcount;

  int checks = 0;
  int errors = 0;

  logic [31:0] frm[$];
  logic [31:0] f1[$];
  logic [37:0] rx[$];
  logic        stall = 1'b0;
  logic [37:0] stall_val = '0;
  logic [3:0]  pat = 4'b1001;

  rx_frame_dispatcher #(.NUM_CH(4), .DEPTH(512), .ADDR_W(9)) dut (
    .clock(clock), .reset(reset), .validin(validin), .sof(sof), .eof(eof),
    .datain(datain), .inthwaddr(inthwaddr), .chkey(chkey), .chmode(chmode),
    .chen(chen), .outvalid(outvalid), .outready(outready), .outsof(outsof),
    .outeof(outeof), .dataout(dataout), .busy(busy), .framecount(framecount),
    .dropcount(dropcount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output side sampled at the falling edge: records accepted words, checks hold under stall.
  always @(negedge clock) begin
    if (reset) begin
      stall = 1'b0;
    end else begin
      if (stall)
        chk("hold", {outvalid, outsof, outeof, dataout}, stall_val);
      if ((outvalid & outready) != 0) begin
        rx.push_back({outvalid, outsof, outeof, dataout});
        stall = 1'b0;
      end else if (outvalid != 0) begin
        stall     = 1'b1;
        stall_val = {outvalid, outsof, outeof, dataout};
      end else begin
        stall = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [3:0] ihl,
                       input logic [7:0] proto, input logic [15:0] port, input int n,
                       input logic [7:0] seed);
    frm.delete();
    for (int i = 0; i < n; i++) begin
      case (i)
        0:       frm.push_back(dst[47:16]);
        1:       frm.push_back({dst[15:0], 16'h0A0B});
        2:       frm.push_back(32'h0C0D_0E0F);
        3:       frm.push_back({et, 4'h4, ihl, 8'h00});
        4:       frm.push_back(32'h1234_4000);
        5:       frm.push_back({24'h4000_00, proto});
        6:       frm.push_back(32'hC0A8_0001);
        7:       frm.push_back(32'hFFFF_FFFF);
        9:       frm.push_back({16'd67, port});
        default: frm.push_back({seed, 8'hA5, 16'(i)});
      endcase
    end
  endtask

  task automatic send_frame;
    for (int i = 0; i < frm.size(); i++) begin
      validin = 1'b1;
      sof     = (i == 0);
      eof     = (i == frm.size() - 1);
      datain  = frm[i];
      tick();
    end
    validin = 1'b0;
    sof     = 1'b0;
    eof     = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int c = 0; c < budget && busy; c++)
      tick();
    chk(tag, busy, 0);
  endtask

  task automatic check_rx(input string tag, input logic [3:0] oh);
    chk(tag, rx.size(), frm.size());
    for (int i = 0; i < frm.size() && i < rx.size(); i++)
      chk(tag, rx[i], {oh, (i == 0), (i == frm.size() - 1), frm[i]});
    rx.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tick(); tick(); tick();
    chk("rst_outvalid", outvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames", framecount, 0);
    chk("rst_drops", dropcount, 0);
    reset = 1'b0;
    tick();

    // Broadcast ARP to channel 0
    build(48'hFFFF_FFFF_FFFF, 16'h0806, 4'd5, 8'd0, 16'd0, 11, 8'h11);
    send_frame();
    tick(); tick();
    chk("arp_latency", (rx.size() > 0), 1);
    wait_idle("arp_idle", 40);
    check_rx("arp_data", 4'b0001);
    chk("arp_frames", framecount, 1);

    // DHCP unicast to channel 1 (UDP port 68)
    build(48'h0200_1122_3344, 16'h0800, 4'd5, 8'd17, 16'd68, 14, 8'h22);
    send_frame();
    wait_idle("dhcp_idle", 40);
    check_rx("dhcp_data", 4'b0010);
    chk("dhcp_frames", framecount, 2);
    chk("dhcp_drops", dropcount, 0);

    // Backpressure 1,0,0,1 on the selected channel; others ready but must be ignored
    build(48'h0200_1122_3344, 16'h0800, 4'd5, 8'd17, 16'd68, 14, 8'h33);
    send_frame();
    for (int c = 0; c < 200 && busy; c++) begin
      outready = {2'b11, pat[c % 4], 1'b1};
      tick();
    end
    chk("bp_idle", busy, 0);
    outready = 4'hF;
    check_rx("bp_data", 4'b0010);
    chk("bp_frames", framecount, 3);

    // Drops: unmatched UDP port, foreign dstMAC, oversized frame
    build(48'h0200_1122_3344, 16'h0800, 4'd5, 8'd17, 16'd1234, 14, 8'h44);
    send_frame();
    wait_idle("port_idle", 20);
    chk("port_rx", rx.size(), 0);
    chk("port_drops", dropcount, 1);

    build(48'h0200_1122_3345, 16'h0806, 4'd5, 8'd0, 16'd0, 11, 8'h55);
    send_frame();
    wait_idle("mac_idle", 20);
    chk("mac_rx", rx.size(), 0);
    chk("mac_drops", dropcount, 2);

    build(48'hFFFF_FFFF_FFFF, 16'h0806, 4'd5, 8'd0, 16'd0, 600, 8'h66);
    send_frame();
    wait_idle("big_idle", 20);
    chk("big_rx", rx.size(), 0);
    chk("big_drops", dropcount, 3);
    chk("big_frames", framecount, 3);

    // Collision: frame 2 arrives while frame 1 is stalled in drain
    outready = 4'h0;
    build(48'hFFFF_FFFF_FFFF, 16'h0806, 4'd5, 8'd0, 16'd0, 11, 8'h77);
    f1 = frm;
    send_frame();
    build(48'hFFFF_FFFF_FFFF, 16'h0806, 4'd5, 8'd0, 16'd0, 30, 8'h88);
    for (int i = 0; i < 30; i++) begin
      validin = 1'b1;
      sof     = (i == 0);
      eof     = (i == 29);
      datain  = frm[i];
      if (i == 5)
        outready = 4'hF;
      if (i == 29) begin
        chk("col_dropwait_busy", busy, 1);
        chk("col_dropwait_valid", outvalid, 0);
      end
      tick();
    end
    validin = 1'b0;
    sof     = 1'b0;
    eof     = 1'b0;
    chk("col_idle", busy, 0);
    frm = f1;
    check_rx("col_data", 4'b0001);
    chk("col_drops", dropcount, 4);
    chk("col_frames", framecount, 4);

    // Single-word frame is dropped in IDLE
    validin = 1'b1; sof = 1'b1; eof = 1'b1; datain = 32'hFFFF_FFFF;
    tick();
    validin = 1'b0; sof = 1'b0; eof = 1'b0;
    chk("oneword_busy", busy, 0);
    chk("oneword_drops", dropcount, 5);

    // Asynchronous reset after 3 drained words
    build(48'hFFFF_FFFF_FFFF, 16'h0806, 4'd5, 8'd0, 16'd0, 11, 8'h99);
    send_frame();
    for (int c = 0; c < 50 && rx.size() < 3; c++)
      tick();
    chk("rst_mid_words", rx.size(), 3);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_outvalid", outvalid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_frames", framecount, 0);
    chk("rst_mid_drops", dropcount, 0);
    chk("rst_mid_data", {outsof, outeof, dataout}, 0);
    tick();
    reset = 1'b0;
    rx.delete();
    tick();

    build(48'h0200_1122_3344, 16'h0800, 4'd5, 8'd17, 16'd68, 12, 8'hAA);
    send_frame();
    wait_idle("post_rst_idle", 40);
    check_rx("post_rst_data", 4'b0010);
    chk("post_rst_frames", framecount, 1);
    chk("post_rst_drops", dropcount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_dispatcher.md
Name: rx_frame_dispatcher

Overview:
Parametrised store-and-forward receive dispatcher. It replaces the fixed ARP/DHCP/UDP split of the FPGA2 receive path with a NUM_CH-way router. One MAC-side 32-bit frame is buffered at a time, classified by destination MAC plus a per-channel ethertype or UDP-port key, then replayed to the single winning channel under a valid/ready handshake. Unmatched, short, oversized or colliding frames are dropped and counted.

Parameters:
NUM_CH, 4, number of output channels (1..8); lowest index has highest priority.
DEPTH, 512, frame buffer depth in 32-bit words; this is the maximum frame length.
ADDR_W, 9, buffer address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
validin  in  1  datain valid this cycle.
sof  in  1  first word of frame; qualified by validin.
eof  in  1  last word of frame; qualified by validin.
datain  in  32  frame word, big-endian; first byte is on [31:24].
inthwaddr  in  48  own MAC address.
chkey  in  16*NUM_CH  match key; channel i uses bits [16i+15:16i].
chmode  in  NUM_CH  per channel: 0 = match ethertype, 1 = match UDP destination port.
chen  in  NUM_CH  per-channel enable.
outvalid  out  NUM_CH  one-hot; the selected channel's word is valid.
outready  in  NUM_CH  per-channel ready.
outsof  out  1  first word of the replayed frame.
outeof  out  1  last word of the replayed frame.
dataout  out  32  replayed frame word.
busy  out  1  high in any state other than IDLE.
framecount  out  16  frames forwarded; wraps.
dropcount  out  16  frames dropped; saturates at 0xFFFF.

Behaviour:
- Reset: all outputs are 0 and the state machine goes to IDLE. A frame in progress is discarded and not counted. Buffer contents are don't-care.
- Header fields, indexed by word number w from 0:
  - dstMAC = {w0, w1[31:16]}
  - ethertype = w3[31:16]
  - IHL = w3[11:8]
  - IP protocol = w5[7:0]
  - UDP destination port = w9[15:0]
- Fields are captured into registers as the words arrive; there is no RAM read-back during classification.
- States: IDLE, RECV, CLASSIFY, DRAIN, DROPWAIT.
- IDLE:
  - validin&sof writes word 0 at address 0 and goes to RECV.
  - validin&sof&eof (1-word frame) counts a drop and stays in IDLE.
  - validin without sof is ignored.
- RECV:
  - Each validin writes the next address; the word count increments.
  - validin&eof goes to CLASSIFY.
  - validin&sof before eof aborts the current frame: dropcount+1, and the new frame restarts at address 0 in the same cycle.
  - A word beyond DEPTH sets an overflow flag; no further writes occur. At eof the frame is dropped.
- CLASSIFY (exactly 1 cycle). Channel i matches when all of the following hold:
  - chen[i] = 1.
  - dstMAC == inthwaddr or dstMAC == 48'hFFFF_FFFF_FFFF.
  - No overflow and length >= 4 words.
  - Mode 0: ethertype == key.
  - Mode 1: ethertype == 0x0800, IHL == 5, protocol == 17, length >= 10 words, and UDP port == key.
- CLASSIFY outcome:
  - The lowest-index matching channel is latched and the state goes to DRAIN.
  - If no channel matches: dropcount+1 and back to IDLE.
- DRAIN:
  - The latched channel's outvalid is high with dataout = buffer[rdaddr], starting at rdaddr 0.
  - outsof is high on word 0; outeof is high on word length-1.
  - A word transfers when outvalid&outready[ch]. dataout, outsof and outeof hold stable while the word is not accepted.
  - The first word is presented within 2 cycles of entering DRAIN, and words stream at 1 per cycle under continuous ready.
  - After the eof transfer: framecount+1, outvalid deasserts, and the state goes to IDLE.
  - outready of non-selected channels is ignored.
- Frames arriving during CLASSIFY or DRAIN (validin&sof) are not stored.
  - dropcount+1 is counted once per such sof.
  - If the frame has not ended when DRAIN finishes, go to DROPWAIT, which discards words until validin&eof and then returns to IDLE.
  - A sof seen in DROPWAIT counts one more drop.
- A sof in the same cycle as the final DRAIN transfer is also dropped.
- Simultaneous drop events in one cycle increment dropcount by at most 1.
- busy is registered and is high in RECV, CLASSIFY, DRAIN and DROPWAIT.

Test Plan:
- Broadcast ARP: 11-word frame, dstMAC FFFF_FFFF_FFFF, ethertype 0x0806; channel 0 set to mode 0, key 0x0806, enabled; outready all 1. Required: 11 words on outvalid=4'b0001, outsof on word 0, outeof on word 10, framecount=1.
- DHCP: unicast to inthwaddr, IPv4 with IHL 5 and protocol 17, UDP port 68; channel 1 set to mode 1, key 68; channel 0 as above. Required: routed to channel 1 only, data bit-exact.
- Backpressure: same frame with outready[1] toggling 1,0,0,1 repeatedly. Required: every word is delivered exactly once, in order, and dataout is stable while not ready.
- Drops:
  - UDP port 1234 with no matching channel.
  - dstMAC mismatch.
  - A 600-word frame with DEPTH 512.
  - In every case: no outvalid; dropcount increments by 1 per frame.
- Collision: a second sof arrives while frame 1 is draining with outready held 0. Required: frame 1 is delivered intact, frame 2 is dropped, dropcount=1, and the state returns to IDLE only after frame 2's eof.
- Reset mid-DRAIN after 3 words. Required: outvalid=0, counters=0, busy=0 immediately (asynchronously); a following valid frame dispatches normally.
